rptr_empty: RTL and testbench
=============================

# rptr_empty

Read-side pointer and status controller for the dual-clock FIFO; the counterpart of the write-pointer/full block. It runs entirely in the read clock domain. It advances a binary/Gray read pointer on accepted reads and drives the memory read address. It compares its pointer against the write pointer synchronized into this domain to produce a registered `empty` flag, a fill level, an `almost_empty` threshold flag and a sticky underflow error. Its Gray `rptr` output crosses to the write domain through the 2-FF synchronizer feeding `rptr_sync` of the write side.

## Interface
- `ADDR_WIDTH`, default 3: memory address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `AE_THRESH`, default 1: `almost_empty` asserts when level <= AE_THRESH; legal range 0 .. 2^ADDR_WIDTH-1.

Ports:
- `rclk` in 1: read clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rinc` in 1: read request; accepted only when `empty`=0.
- `wptr_sync` in ADDR_WIDTH+1: write-pointer Gray code, already synchronized into rclk.
- `underflow_clr` in 1: clears sticky `underflow`.
- `rptr` out ADDR_WIDTH+1: read pointer, Gray code, registered.
- `raddr` out ADDR_WIDTH: memory read address = low bits of binary read pointer.
- `empty` out 1: registered empty flag.
- `almost_empty` out 1: registered, level <= AE_THRESH.
- `rlevel` out ADDR_WIDTH+1: registered fill level as seen by the read side, 0 .. 2^ADDR_WIDTH.
- `underflow` out 1: sticky, read attempted while empty.

## Operation
- State: binary pointer `rbin`, Gray pointer `rgray`, and registers for `empty`, `almost_empty`, `rlevel` and `underflow`.
- Accept = `rinc & ~empty`; `rbin_next = rbin + accept`, mod 2^(ADDR_WIDTH+1); `rgray_next = (rbin_next >> 1) ^ rbin_next`.
- Each edge: `rbin <= rbin_next`, `rgray <= rgray_next`; `rptr = rgray`, `raddr = rbin[ADDR_WIDTH-1:0]`.
- Empty: `empty <= (rgray_next == wptr_sync)`, full-width compare including MSB.
- Level:
  - `wbin_s` = Gray-to-binary of `wptr_sync`, an XOR prefix from the MSB down.
  - `rlevel <= wbin_s - rbin_next`, mod 2^(ADDR_WIDTH+1).
  - `almost_empty <= (wbin_s - rbin_next) <= AE_THRESH`.
  - `rlevel`=0 exactly when `empty` is 1.
- Underflow:
  - `rinc & empty` sets `underflow` on the next edge; pointers do not move.
  - `underflow_clr` clears it; when set and clear occur together, set wins.
- Read data: the external memory is read combinationally at `raddr`. The head word is valid whenever `empty`=0.
- Pointer wrap: both pointers wrap at 2^(ADDR_WIDTH+1). `raddr` wraps from 2^ADDR_WIDTH-1 to 0 with no special handling.
- Reset (asynchronous, any time, including mid-stream):
  - `rbin`/`rptr`/`raddr`/`rlevel` = 0, `empty`=1, `almost_empty`=1, `underflow`=0.
  - The write side must be reset in the same event.

## Timing
- Accepted `rinc` in cycle N: `rptr`, `raddr`, `empty`, `rlevel` and `almost_empty` all reflect the read after edge N+1.
- A `wptr_sync` change in cycle N is reflected in `empty`/`rlevel` after edge N+1. End-to-end write-to-not-empty latency is synchronizer depth + 1 rclk.
- A simultaneous read and `wptr_sync` advance combine in one update; e.g. level 1 with both gives level 1, `empty`=0.
- `empty` is pessimistic: it can lag writes but never deasserts falsely, because `wptr_sync` is always stale-low.
- `rptr` changes at most one bit per rclk edge (Gray property), which makes it safe for the write-domain synchronizer.

## Test plan
- Reset: assert `rst_n`=0 mid-run with `rinc`=1 -> outputs go immediately to `rptr`=0, `raddr`=0, `empty`=1, `almost_empty`=1, `rlevel`=0, `underflow`=0. After release, the first edge with `wptr_sync`=0 keeps `empty`=1.
- Single word:
  - `wptr_sync`=4'b0001 -> next edge `empty`=0, `rlevel`=1, `almost_empty`=1.
  - `rinc` one cycle -> `rptr`=4'b0001, `raddr`=1, `empty`=1, `rlevel`=0.
- Full drain: `wptr_sync`=4'b1100 (binary 8) -> `rlevel`=8, `almost_empty`=0. Eight back-to-back reads -> `raddr` goes 1..7 then 0, `almost_empty` rises when level reaches 1, `empty`=1 and `rptr`=4'b1100 after the 8th.
- Wrap: preload pointers to binary 15 (`rptr`=4'b1000); with `wptr_sync`=4'b0000 (binary 0, one word ahead), `rlevel`=1. Read -> `rptr`=4'b0000, `empty`=1.
- Underflow:
  - `rinc` while `empty` -> pointers unchanged, `underflow`=1 and holds.
  - `underflow_clr` + `rinc` (still empty) in the same cycle -> stays 1.
  - `underflow_clr` alone -> 0.
- Simultaneous events: level 1, `rinc`=1 while `wptr_sync` advances by one in the same cycle -> `empty` stays 0, `rlevel`=1, `rptr` advances by one.

Source files
------------

// File: rtl/rptr_empty_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rptr_empty_if : read-side FIFO control bundle (rclk domain)      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface rptr_empty_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  rinc;
  logic [ADDR_WIDTH:0]   wptr_sync;
  logic                  underflow_clr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rlevel;
  logic                  underflow;

  modport master (
    output rinc, wptr_sync, underflow_clr,
    input  rptr, raddr, empty, almost_empty, rlevel, underflow
  );

  modport slave (
    input  rinc, wptr_sync, underflow_clr,
    output rptr, raddr, empty, almost_empty, rlevel, underflow
  );
endinterface
`default_nettype wire

// File: rtl/rptr_empty.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rptr_empty : dual-clock FIFO read pointer, empty/level/underflow |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rptr_empty #(
  parameter int ADDR_WIDTH = 3,
  parameter int AE_THRESH  = 1
) (
  input  wire logic       rclk,
  input  wire logic       rst_n,
  rptr_empty_if.slave     bus
);
  localparam int                c_PW        = ADDR_WIDTH + 1;
  localparam logic [c_PW-1:0]   c_AE_THRESH = c_PW'(AE_THRESH);

  logic [c_PW-1:0] r_rbin;
  logic [c_PW-1:0] r_rgray;
  logic            r_empty;
  logic            r_almost_empty;
  logic [c_PW-1:0] r_rlevel;
  logic            r_underflow;

  logic            w_accept;
  logic [c_PW-1:0] w_rbin_next;
  logic [c_PW-1:0] w_rgray_next;
  logic [c_PW-1:0] w_wbin_s;
  logic [c_PW-1:0] w_level_next;

  assign w_accept     = bus.rinc & ~r_empty;
  assign w_rbin_next  = r_rbin + {{(c_PW-1){1'b0}}, w_accept};
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  generate
    for (genvar i = 0; i < c_PW; i++) begin : g_g2b
      assign w_wbin_s[i] = ^(bus.wptr_sync >> i);
    end
  endgenerate

  assign w_level_next = w_wbin_s - w_rbin_next;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbin         <= '0;
      r_rgray        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rlevel       <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_rbin         <= w_rbin_next;
      r_rgray        <= w_rgray_next;
      r_empty        <= (w_rgray_next == bus.wptr_sync);
      r_almost_empty <= (w_level_next <= c_AE_THRESH);
      r_rlevel       <= w_level_next;
      // A new underflow in the same cycle as a clear must not be lost.
      if (bus.rinc && r_empty)
        r_underflow <= 1'b1;
      else if (bus.underflow_clr)
        r_underflow <= 1'b0;
    end
  end

  assign bus.rptr         = r_rgray;
  assign bus.raddr        = r_rbin[ADDR_WIDTH-1:0];
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_almost_empty;
  assign bus.rlevel       = r_rlevel;
  assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_rptr_empty.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rptr_empty : directed bench for rptr_empty (ADDR_WIDTH=3)     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_rptr_empty;
  logic rclk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rptr_empty_if #(.ADDR_WIDTH(3)) bus ();

  rptr_empty #(.ADDR_WIDTH(3), .AE_THRESH(1)) u_dut (
    .rclk  (rclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".rptr"},  int'(bus.rptr),         0);
    check({tag, ".raddr"}, int'(bus.raddr),        0);
    check({tag, ".empty"}, int'(bus.empty),        1);
    check({tag, ".ae"},    int'(bus.almost_empty), 1);
    check({tag, ".level"}, int'(bus.rlevel),       0);
    check({tag, ".uf"},    int'(bus.underflow),    0);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst_n             = 1'b0;
    bus.rinc          = 1'b0;
    bus.wptr_sync     = 4'b0000;
    bus.underflow_clr = 1'b0;
    tick();
    tick();
    check_reset_state("por");
    rst_n = 1'b1;
    tick();
    check("rel.empty", int'(bus.empty), 1);

    // Single word
    bus.wptr_sync = 4'b0001;
    tick();
    check("one.empty", int'(bus.empty),        0);
    check("one.level", int'(bus.rlevel),       1);
    check("one.ae",    int'(bus.almost_empty), 1);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("rd1.rptr",  int'(bus.rptr),   1);
    check("rd1.raddr", int'(bus.raddr),  1);
    check("rd1.empty", int'(bus.empty),  1);
    check("rd1.level", int'(bus.rlevel), 0);

    // Mid-stream asynchronous reset while reading
    bus.wptr_sync = 4'b1100;
    tick();
    check("pre.level", int'(bus.rlevel), 7);
    bus.rinc = 1'b1;
    tick();
    check("pre.raddr", int'(bus.raddr), 2);
    #2;
    rst_n         = 1'b0;
    bus.wptr_sync = 4'b0000;
    #1;
    check_reset_state("arst");
    tick();
    check("arst_hold.rptr", int'(bus.rptr), 0);
    rst_n    = 1'b1;
    bus.rinc = 1'b0;
    tick();
    check("arst_rel.empty", int'(bus.empty), 1);

    // Full drain of eight words
    bus.wptr_sync = 4'b1100;
    tick();
    check("full.level", int'(bus.rlevel),       8);
    check("full.ae",    int'(bus.almost_empty), 0);
    check("full.empty", int'(bus.empty),        0);
    bus.rinc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("drain%0d.raddr", k), int'(bus.raddr), k % 8);
      check($sformatf("drain%0d.level", k), int'(bus.rlevel), 8 - k);
      check($sformatf("drain%0d.ae", k), int'(bus.almost_empty), (8 - k) <= 1 ? 1 : 0);
    end
    bus.rinc = 1'b0;
    check("drain.empty", int'(bus.empty), 1);
    check("drain.rptr",  int'(bus.rptr),  4'b1100);

    // Walk the read pointer to binary 15, then cross the pointer wrap
    bus.wptr_sync = 4'b1000;
    tick();
    check("w15.level", int'(bus.rlevel), 7);
    bus.rinc = 1'b1;
    repeat (7) tick();
    bus.rinc = 1'b0;
    check("r15.rptr",  int'(bus.rptr),  4'b1000);
    check("r15.empty", int'(bus.empty), 1);
    bus.wptr_sync = 4'b0000;
    tick();
    check("wrap.level", int'(bus.rlevel), 1);
    check("wrap.empty", int'(bus.empty),  0);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("wrap.rptr",  int'(bus.rptr),   0);
    check("wrap.raddr", int'(bus.raddr),  0);
    check("wrap.empty", int'(bus.empty),  1);
    check("wrap.lvl0",  int'(bus.rlevel), 0);
    check("wrap.uf",    int'(bus.underflow), 0);

    // Underflow: set, hold, set-beats-clear, clear
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("uf.set",  int'(bus.underflow), 1);
    check("uf.rptr", int'(bus.rptr),      0);
    tick();
    check("uf.hold", int'(bus.underflow), 1);
    bus.rinc          = 1'b1;
    bus.underflow_clr = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("uf.setwins", int'(bus.underflow), 1);
    check("uf.rptr2",   int'(bus.rptr),      0);
    tick();
    bus.underflow_clr = 1'b0;
    check("uf.clr", int'(bus.underflow), 0);

    // Read and write-pointer advance in the same cycle
    bus.wptr_sync = 4'b0001;
    tick();
    check("sim.pre", int'(bus.rlevel), 1);
    bus.rinc      = 1'b1;
    bus.wptr_sync = 4'b0011;
    tick();
    bus.rinc = 1'b0;
    check("sim.empty", int'(bus.empty),  0);
    check("sim.level", int'(bus.rlevel), 1);
    check("sim.rptr",  int'(bus.rptr),   1);
    check("sim.ae",    int'(bus.almost_empty), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
